// File: rtl/game_fsm.sv
// Game flow controller: menu, play, death delay and end screen.
// Optional timed return from the end screen: define GAME_FSM_AUTO_RETURN_EN.
module game_fsm #(
    parameter int unsigned DEATH_DELAY_FRAMES = 60,
    parameter int unsigned AUTO_RETURN_FRAMES = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       back_to_menu,
    input  logic [1:0] class_req,
    input  logic       class_req_valid,
    input  logic       player_hp_zero,
    input  logic       boss_hp_zero,
    input  logic       frame_tick,
    output logic [1:0] game_active,
    output logic [1:0] char_class,
    output logic       game_won,
    output logic       game_reset
);

    typedef enum logic [1:0] {
        S_MENU,
        S_PLAY,
        S_DYING,
        S_OVER
    } state_t;

    localparam logic [7:0] DEATH_LAST = 8'(DEATH_DELAY_FRAMES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_active;
    logic [1:0] r_class;
    logic       r_won;
    logic       r_reset;

    logic w_class_ok;
    logic w_leave_over;

    assign w_class_ok = class_req_valid && (class_req != 2'd0);

`ifdef GAME_FSM_AUTO_RETURN_EN
    localparam logic [7:0] AUTO_LAST = 8'(AUTO_RETURN_FRAMES - 1);
    logic w_auto_done;
    assign w_auto_done  = frame_tick && (r_cnt == AUTO_LAST);
    // A coincident button press and timeout collapse into one return
    assign w_leave_over = back_to_menu || w_auto_done;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = AUTO_RETURN_FRAMES[0];
    assign w_leave_over = back_to_menu;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_MENU;
            r_cnt    <= 8'd0;
            r_active <= 2'd0;
            r_class  <= 2'd0;
            r_won    <= 1'b0;
            r_reset  <= 1'b0;
        end else begin
            r_reset <= 1'b0;
            case (r_state)
                S_MENU: begin
                    if (w_class_ok) begin
                        r_class <= class_req;
                    end
                    // Start is judged on the class held before this edge
                    if (game_start && (r_class != 2'd0)) begin
                        r_state  <= S_PLAY;
                        r_active <= 2'd1;
                        r_reset  <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (player_hp_zero || boss_hp_zero) begin
                        r_state <= S_DYING;
                        r_cnt   <= 8'd0;
                        r_won   <= ~player_hp_zero;
                    end
                end
                S_DYING: begin
                    if (frame_tick) begin
                        if (r_cnt == DEATH_LAST) begin
                            r_state  <= S_OVER;
                            r_active <= 2'd2;
                            r_cnt    <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_OVER: begin
                    if (w_leave_over) begin
                        r_state  <= S_MENU;
                        r_active <= 2'd0;
                        r_class  <= 2'd0;
                        r_won    <= 1'b0;
                        r_cnt    <= 8'd0;
                    end else if (frame_tick) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state  <= S_MENU;
                    r_active <= 2'd0;
                end
            endcase
        end
    end

    assign game_active = r_active;
    assign char_class  = r_class;
    assign game_won    = r_won;
    assign game_reset  = r_reset;

endmodule

// File: tb/tb_game_fsm.sv
// Directed plus randomized bench for game_fsm against a countdown model.
// Honours GAME_FSM_AUTO_RETURN_EN the same way as the design.
module tb_game_fsm;

    localparam int DD = 3;
    localparam int AR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_start = 1'b0;
    logic       back_to_menu = 1'b0;
    logic [1:0] class_req = 2'd0;
    logic       class_req_valid = 1'b0;
    logic       player_hp_zero = 1'b0;
    logic       boss_hp_zero = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] game_active;
    logic [1:0] char_class;
    logic       game_won;
    logic       game_reset;

    int checks = 0;
    int failures = 0;

    // Reference model: screen, dying flag, ticks still to wait
    int         e_screen;
    bit         e_dying;
    int         e_left;
    logic [1:0] e_cls;
    logic       e_won;
    logic       e_pulse;

    game_fsm #(
        .DEATH_DELAY_FRAMES(DD),
        .AUTO_RETURN_FRAMES(AR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .game_start     (game_start),
        .back_to_menu   (back_to_menu),
        .class_req      (class_req),
        .class_req_valid(class_req_valid),
        .player_hp_zero (player_hp_zero),
        .boss_hp_zero   (boss_hp_zero),
        .frame_tick     (frame_tick),
        .game_active    (game_active),
        .char_class     (char_class),
        .game_won       (game_won),
        .game_reset     (game_reset)
    );

    always #5 clk = ~clk;

    task automatic to_menu();
        e_screen = 0;
        e_dying  = 0;
        e_left   = 0;
        e_cls    = 2'd0;
        e_won    = 1'b0;
    endtask

    task automatic model(input bit gs, btm, input logic [1:0] cr,
                         input bit crv, php, bhp, ft, r);
        bit go;
        e_pulse = 1'b0;
        if (r) begin
            to_menu();
        end else if (e_screen == 0) begin
            go = gs && (e_cls != 2'd0);
            if (crv && cr != 2'd0) e_cls = cr;
            if (go) begin
                e_screen = 1;
                e_dying  = 0;
                e_pulse  = 1'b1;
            end
        end else if (e_screen == 1 && !e_dying) begin
            if (php || bhp) begin
                e_dying = 1;
                e_left  = DD;
                e_won   = !php;
            end
        end else if (e_screen == 1) begin
            if (ft) begin
                e_left--;
                if (e_left == 0) begin
                    e_screen = 2;
                    e_dying  = 0;
                    e_left   = AR;
                end
            end
        end else begin
            if (btm) begin
                to_menu();
            end else if (ft) begin
`ifdef GAME_FSM_AUTO_RETURN_EN
                e_left--;
                if (e_left == 0) to_menu();
`endif
            end
        end
    endtask

    task automatic chk(input string tag);
        checks++;
        assert (game_active === 2'(e_screen)) else begin
            failures++;
            $error("FAIL %s game_active got=%0d exp=%0d", tag, game_active, e_screen);
        end
        checks++;
        assert (char_class === e_cls) else begin
            failures++;
            $error("FAIL %s char_class got=%0d exp=%0d", tag, char_class, e_cls);
        end
        checks++;
        assert (game_won === e_won) else begin
            failures++;
            $error("FAIL %s game_won got=%0d exp=%0d", tag, game_won, e_won);
        end
        checks++;
        assert (game_reset === e_pulse) else begin
            failures++;
            $error("FAIL %s game_reset got=%0d exp=%0d", tag, game_reset, e_pulse);
        end
    endtask

    task automatic step(input string tag, input bit gs, btm,
                        input logic [1:0] cr, input bit crv, php, bhp, ft, r);
        game_start      = gs;
        back_to_menu    = btm;
        class_req       = cr;
        class_req_valid = crv;
        player_hp_zero  = php;
        boss_hp_zero    = bhp;
        frame_tick      = ft;
        rst             = r;
        @(posedge clk);
        #1;
        model(gs, btm, cr, crv, php, bhp, ft, r);
        chk(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick(input string tag);
        step(tag, 0, 0, 2'd0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        to_menu();
        e_pulse = 1'b0;

        step("reset", 1, 1, 2'd3, 1, 1, 1, 1, 1);
        step("reset2", 0, 0, 2'd0, 0, 0, 0, 0, 1);

        step("start_no_class", 1, 0, 2'd0, 0, 0, 0, 0, 0);
        step("class_zero_ignored", 0, 0, 2'd0, 1, 0, 0, 0, 0);
        step("start_no_class2", 1, 0, 2'd0, 0, 0, 0, 0, 0);

        step("class2", 0, 0, 2'd2, 1, 0, 0, 0, 0);
        step("start", 1, 0, 2'd0, 0, 0, 0, 0, 0);
        idle("reset_pulse_end");
        step("play_ignores", 1, 1, 2'd3, 1, 0, 0, 1, 0);

        step("boss_dead", 0, 0, 2'd0, 0, 0, 1, 0, 0);
        step("dying_hp_ignored", 0, 0, 2'd0, 0, 1, 0, 0, 0);
        tick("die_t1");
        idle("die_gap");
        tick("die_t2");
        tick("die_t3_over_win");
        step("over_ignores_start", 1, 0, 2'd1, 1, 0, 0, 0, 0);
        step("back_to_menu", 0, 1, 2'd0, 0, 0, 0, 0, 0);

        step("class1", 0, 0, 2'd1, 1, 0, 0, 0, 0);
        step("start_update_same", 1, 0, 2'd3, 1, 0, 0, 0, 0);
        step("both_dead", 0, 0, 2'd0, 0, 1, 1, 0, 0);
        for (int i = 0; i < DD; i++) tick("lose_tick");
        for (int i = 0; i < 300; i++) tick("over_ticks");
        step("btm_after_ticks", 0, 1, 2'd0, 0, 0, 0, 1, 0);

        step("class_start_from_zero", 1, 0, 2'd3, 1, 0, 0, 0, 0);
        step("start_again", 1, 0, 2'd0, 0, 0, 0, 0, 0);
        step("player_dead", 0, 0, 2'd0, 0, 1, 0, 0, 0);
        tick("die_one_tick");
        step("rst_mid_dying", 0, 0, 2'd0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) tick("no_over_after_rst");

        for (int i = 0; i < 3000; i++) begin
            step("random",
                 $urandom_range(3) == 0,
                 $urandom_range(5) == 0,
                 2'($urandom_range(3)),
                 $urandom_range(2) == 0,
                 $urandom_range(11) == 0,
                 $urandom_range(11) == 0,
                 $urandom_range(2) == 0,
                 $urandom_range(149) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
